// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding and common constants.
// Both the transmitter and the receiver import this package.
package uart_pkg;

  // 50 MHz system clock divided down to 115200 baud
  localparam int UART_DIV_115200_50M = 434;
  localparam int UART_DATA_BITS      = 8;

  // Frame sequencing states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Parity over a data byte; odd parity is the inverse of the even result
  function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] b,
                                       input logic odd);
    return (^b) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..DIVISOR-1 and flags the last cycle of each bit.
// restart forces the count back to 0 so a new frame starts on a clean bit.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIVISOR = UART_DIV_115200_50M
) (
  input  logic clock,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  if (DIVISOR < 2 || DIVISOR > 65535) begin : g_bad_divisor
    $error("uart_baud_gen: DIVISOR must be in 2..65535");
  end

  localparam logic [15:0] CNT_LAST = 16'(DIVISOR - 1);

  logic [15:0] cnt_q;

  // Free-running bit counter, wraps at the end of each bit period
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              cnt_q <= 16'd0;
    else if (restart)          cnt_q <= 16'd0;
    else if (cnt_q == CNT_LAST) cnt_q <= 16'd0;
    else                       cnt_q <= cnt_q + 16'd1;
  end

  assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. One byte accepted per valid/ready handshake.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DIVISOR    = UART_DIV_115200_50M,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       utx_i_clock,
  input  logic       utx_i_reset_n,
  input  logic       utx_i_valid,
  input  logic [7:0] utx_i_data,
  output logic       utx_o_ready,
  output logic       utx_o_txd,
  output logic       utx_o_busy,
  output logic       utx_o_done
);

  if (DIVISOR < 2 || DIVISOR > 65535) begin : g_bad_divisor
    $error("uart_transmitter: DIVISOR must be in 2..65535");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_transmitter: STOP_BITS must be 1 or 2");
  end

  localparam logic STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic ODD_SEL   = (PARITY_ODD != 0);
  localparam logic PAR_ON    = (PARITY_EN != 0);

  uart_state_t state_q;
  logic [7:0]  shift_q;     // bit 0 is the bit currently on the line
  logic [7:0]  byte_q;      // unshifted copy, used only for parity
  logic [2:0]  bit_idx_q;
  logic        stop_cnt_q;
  logic        txd_q;
  logic        ready_q;
  logic        busy_q;
  logic        done_q;
  logic        accept;
  logic        tick;

  assign accept = (state_q == IDLE) && ready_q && utx_i_valid;

  uart_baud_gen #(
    .DIVISOR (DIVISOR)
  ) u_baud (
    .clock   (utx_i_clock),
    .reset_n (utx_i_reset_n),
    .restart (accept),
    .tick    (tick)
  );

  // Frame sequencer; every output is registered so the line never glitches
  always_ff @(posedge utx_i_clock or negedge utx_i_reset_n) begin
    if (!utx_i_reset_n) begin
      state_q    <= IDLE;
      shift_q    <= 8'd0;
      byte_q     <= 8'd0;
      bit_idx_q  <= 3'd0;
      stop_cnt_q <= 1'b0;
      txd_q      <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          txd_q   <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          if (accept) begin
            state_q    <= START;
            shift_q    <= utx_i_data;
            byte_q     <= utx_i_data;
            bit_idx_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            txd_q      <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state_q <= DATA;
            txd_q   <= shift_q[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx_q == 3'd7) begin
              if (PAR_ON) begin
                state_q <= PARITY;
                txd_q   <= uart_parity(byte_q, ODD_SEL);
              end else begin
                state_q <= STOP;
                txd_q   <= 1'b1;
              end
            end else begin
              // Next bit is shift_q[1]; present it in the same edge as the shift
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 3'd1;
              txd_q     <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state_q <= STOP;
            txd_q   <= 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_cnt_q == STOP_LAST) begin
              state_q <= IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              txd_q   <= 1'b1;
            end else begin
              stop_cnt_q <= stop_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

  assign utx_o_txd   = txd_q;
  assign utx_o_ready = ready_q;
  assign utx_o_busy  = busy_q;
  assign utx_o_done  = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: three instances cover no-parity/1 stop,
// even parity/2 stop and odd parity/2 stop. Expected line levels are queued
// when a byte is offered and popped cycle by cycle as the frame goes out.
module tb_uart_transmitter;
  import uart_pkg::*;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] valid;
  logic [7:0] data [3];
  wire  [2:0] ready, txd, busy, done;

  int total = 0;
  int bad   = 0;
  logic q [$];

  int pe [3] = '{0, 1, 1};
  int po [3] = '{0, 0, 1};
  int sb [3] = '{1, 2, 2};

  always #5 clk = ~clk;

  uart_transmitter #(.DIVISOR(DIV), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .utx_i_clock(clk), .utx_i_reset_n(rst_n), .utx_i_valid(valid[0]), .utx_i_data(data[0]),
    .utx_o_ready(ready[0]), .utx_o_txd(txd[0]), .utx_o_busy(busy[0]), .utx_o_done(done[0]));

  uart_transmitter #(.DIVISOR(DIV), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
    .utx_i_clock(clk), .utx_i_reset_n(rst_n), .utx_i_valid(valid[1]), .utx_i_data(data[1]),
    .utx_o_ready(ready[1]), .utx_o_txd(txd[1]), .utx_o_busy(busy[1]), .utx_o_done(done[1]));

  uart_transmitter #(.DIVISOR(DIV), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
    .utx_i_clock(clk), .utx_i_reset_n(rst_n), .utx_i_valid(valid[2]), .utx_i_data(data[2]),
    .utx_o_ready(ready[2]), .utx_o_txd(txd[2]), .utx_o_busy(busy[2]), .utx_o_done(done[2]));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line levels for one frame, one entry per bit period
  task automatic push_frame(input int k, input logic [7:0] b);
    logic p;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(b[i]);
    if (pe[k] != 0) begin
      p = ^b;
      if (po[k] != 0) p = ~p;
      q.push_back(p);
    end
    for (int i = 0; i < sb[k]; i++) q.push_back(1'b1);
  endtask

  // Offer a byte; it is taken at the next rising edge, then data is scrambled
  task automatic offer(input int k, input logic [7:0] b, input bit hold);
    @(negedge clk);
    chk($sformatf("u%0d_ready_pre", k), 8'(ready[k]), 8'd1);
    valid[k] = 1'b1;
    data[k]  = b;
    push_frame(k, b);
    @(posedge clk);
    #1;
    if (!hold) valid[k] = 1'b0;
    data[k] = ~b;
  endtask

  // Check every cycle of one frame, then the first idle cycle
  task automatic check_frame(input int k);
    int   n;
    logic e;
    n = 1 + 8 + pe[k] + sb[k];
    for (int i = 0; i < n; i++) begin
      if (q.size() == 0) begin
        chk($sformatf("u%0d_queue_empty", k), 8'd0, 8'd1);
        e = 1'b1;
      end else begin
        e = q.pop_front();
      end
      repeat (DIV) begin
        @(negedge clk);
        chk($sformatf("u%0d_txd_bit%0d", k, i), 8'(txd[k]), 8'(e));
        chk($sformatf("u%0d_busy", k), 8'(busy[k]), 8'd1);
        chk($sformatf("u%0d_ready_low", k), 8'(ready[k]), 8'd0);
        chk($sformatf("u%0d_done_early", k), 8'(done[k]), 8'd0);
      end
    end
    @(negedge clk);
    chk($sformatf("u%0d_done_pulse", k), 8'(done[k]), 8'd1);
    chk($sformatf("u%0d_ready_rise", k), 8'(ready[k]), 8'd1);
    chk($sformatf("u%0d_busy_fall", k), 8'(busy[k]), 8'd0);
    chk($sformatf("u%0d_idle_txd", k), 8'(txd[k]), 8'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    valid = 3'b000;
    for (int k = 0; k < 3; k++) data[k] = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d_rst_txd", k), 8'(txd[k]), 8'd1);
      chk($sformatf("u%0d_rst_ready", k), 8'(ready[k]), 8'd1);
      chk($sformatf("u%0d_rst_busy", k), 8'(busy[k]), 8'd0);
      chk($sformatf("u%0d_rst_done", k), 8'(done[k]), 8'd0);
    end
    rst_n = 1'b1;

    // Idle for 50 cycles: line high, ready, never done
    repeat (50) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("u%0d_idle_txd", k), 8'(txd[k]), 8'd1);
        chk($sformatf("u%0d_idle_ready", k), 8'(ready[k]), 8'd1);
        chk($sformatf("u%0d_idle_busy", k), 8'(busy[k]), 8'd0);
        chk($sformatf("u%0d_idle_done", k), 8'(done[k]), 8'd0);
      end
    end

    // 0x55, no parity, one stop bit
    offer(0, 8'h55, 1'b0);
    check_frame(0);

    // 0xA3, even parity, two stop bits
    offer(1, 8'hA3, 1'b0);
    check_frame(1);

    // 0xA3, odd parity, two stop bits
    offer(2, 8'hA3, 1'b0);
    check_frame(2);

    // Back-to-back: valid held, 0x00 then 0xFF (data changes mid frame 1)
    offer(0, 8'h00, 1'b1);
    data[0] = 8'hFF;
    push_frame(0, 8'hFF);
    check_frame(0);
    @(posedge clk);
    #1;
    valid[0] = 1'b0;
    check_frame(0);

    // Reset in the middle of data bit 3 (bit 3 of 0x00 is low)
    offer(0, 8'h00, 1'b0);
    q.delete();
    repeat (18) @(negedge clk);
    chk("u0_bit3_low", 8'(txd[0]), 8'd0);
    chk("u0_bit3_busy", 8'(busy[0]), 8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("u0_async_txd", 8'(txd[0]), 8'd1);
    chk("u0_async_ready", 8'(ready[0]), 8'd1);
    chk("u0_async_busy", 8'(busy[0]), 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      chk("u0_post_rst_state", 8'(u0.state_q), 8'(IDLE));
      chk("u0_post_rst_ready", 8'(ready[0]), 8'd1);
      chk("u0_post_rst_done", 8'(done[0]), 8'd0);
      chk("u0_post_rst_txd", 8'(txd[0]), 8'd1);
    end
    offer(0, 8'h3C, 1'b0);
    check_frame(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Serial UART transmitter; the sending end of the link that the uart_receiver2 example receives.
- Accepts one byte per valid/ready handshake and shifts it out on a single line.
- Frame: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Sits beside reset_delay; its reset input is normally driven from the delayed-reset output.

Parameters:
- DIVISOR, 434, clock cycles per bit (50 MHz / 115200 baud); legal range 2..65535.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- utx_i_clock  input  1  system clock; all logic is rising-edge.
- utx_i_reset_n  input  1  asynchronous active-low reset.
- utx_i_valid  input  1  byte offered on utx_i_data.
- utx_i_data  input  8  byte to send; sampled only at acceptance.
- utx_o_ready  output  1  transmitter can accept a byte this cycle.
- utx_o_txd  output  1  serial line; idles high.
- utx_o_busy  output  1  a frame is in progress.
- utx_o_done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: utx_o_txd=1, utx_o_ready=1, utx_o_busy=0, utx_o_done=0, state=IDLE, counters=0.
- Reset assertion mid-frame: txd returns high immediately (asynchronously). The frame is abandoned and nothing is replayed.
- States and transitions:
  - IDLE: txd=1, ready=1, busy=0.
  - IDLE -> START at the rising edge where valid=1 and ready=1. At that edge: data latched into the shift register, txd<=0, baud count<=0, bit index<=0.
  - START -> DATA.
  - DATA -> PARITY when PARITY_EN=1, otherwise DATA -> STOP.
  - PARITY -> STOP.
  - STOP -> IDLE.
- Bit timing: every bit holds for exactly DIVISOR cycles. The baud counter runs 0..DIVISOR-1; the bit or state advances on the cycle the counter equals DIVISOR-1, with a registered txd update on that edge.
- DATA: shift-register bit 0 is driven on txd. The register shifts right at each bit boundary, 8 bits total, index 0..7.
- Parity bit value:
  - Even: XOR of the 8 latched bits.
  - Odd: inverse of that XOR.
  - Computed from the latched copy, never from the live utx_i_data.
- STOP: txd=1 for STOP_BITS*DIVISOR cycles.
- Frame length: (1+8+PARITY_EN+STOP_BITS)*DIVISOR cycles, measured from the first txd-low cycle to the first IDLE cycle.
- ready and busy:
  - ready=0 and busy=1 from the cycle after acceptance through the last stop-bit cycle.
  - ready returns to 1 in the first IDLE cycle.
- done: high for exactly that first IDLE cycle.
- Back-to-back transfers: if valid is held, the next byte is accepted in the first IDLE cycle. The line then idles high for stop time plus exactly 1 cycle before the next start bit.
- Input changes: changes on utx_i_data or utx_i_valid while ready=0 are ignored.
- Widths: baud counter 16 bits unsigned, bit index 3 bits, stop counter 1 bit. No other arithmetic.
- DIVISOR outside 2..65535 or STOP_BITS not in {1,2}: elaboration-time error.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding: IDLE, START, DATA, PARITY, STOP
  - constant UART_DIV_115200_50M=434
  - constant UART_DATA_BITS=8
- The receiver imports the same package.
- One natural sub-module: uart_baud_gen.
  - Parameterised by DIVISOR; has clock, reset and a restart input.
  - Outputs a one-cycle tick when the count reaches DIVISOR-1.
  - The transmitter asserts restart at acceptance.

Test Plan (DIVISOR=4 unless noted):
- Reset, then idle 50 cycles -> txd=1, ready=1, busy=0, done never high.
- Send 0x55, PARITY_EN=0 -> txd sequence 0,1,0,1,0,1,0,1,0,1, each 4 cycles. done pulses exactly 40 cycles after the first low cycle, in the same cycle ready rises.
- Send 0xA3 with PARITY_EN=1, PARITY_ODD=0, STOP_BITS=2 -> data bits 1,1,0,0,0,1,0,1, parity 0, two stop bits, total frame 48 cycles.
- Repeat the 0xA3 case with PARITY_ODD=1 -> parity bit 1.
- valid held high with bytes 0x00 then 0xFF -> second start bit falls exactly 1 cycle after the first frame's stop time. Data on utx_i_data changed during frame 1 does not corrupt frame 1.
- Assert reset in the middle of DATA bit 3 -> txd=1 in the same cycle without waiting for a clock edge. After release: state IDLE, ready=1, no done pulse, and a new byte 0x3C is sent cleanly.
